csr_issue: RTL and testbench

//  Execute-stage initiator for the CSR register file. Accepts one decoded Zicsr

---
 rtl/csr_issue_pkg.sv | 54 +++++
 rtl/csr_issue.sv | 117 +++++++++++
 tb/tb_csr_issue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_issue_pkg.sv
// rtl/csr_issue_pkg.sv - shared CSR op codes, funct3 codes, FSM states and op/enable decode for csr_issue
package csr_issue_pkg;

  localparam logic [1:0] CSR_RW = 2'b01;
  localparam logic [1:0] CSR_RS = 2'b10;
  localparam logic [1:0] CSR_RC = 2'b11;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // addr[11:10] value marking the read-only CSR range
  localparam logic [1:0] CSR_RO_RANGE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid_op;
    logic       rena;
    logic       wena;
    logic [1:0] op;
  } csr_dec_t;

  // RW skips the read when rd is x0; RS/RC skip the write when the source is zero
  function automatic csr_dec_t csr_decode(input logic [2:0] funct3,
                                          input logic       rd_zero,
                                          input logic       src_zero);
    csr_dec_t d;
    d.op       = funct3[1:0];
    d.valid_op = (funct3[1:0] != 2'b00);
    d.rena     = 1'b0;
    d.wena     = 1'b0;
    case (funct3[1:0])
      CSR_RW: begin
        d.rena = !rd_zero;
        d.wena = 1'b1;
      end
      CSR_RS, CSR_RC: begin
        d.rena = 1'b1;
        d.wena = !src_zero;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csr_issue.sv
// rtl/csr_issue.sv - execute-stage Zicsr initiator, one CSR instruction in flight
// Optional CSR_ILLEGAL_CHECK_EN: flags invalid funct3 and writes to read-only CSRs.
module csr_issue
  import csr_issue_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic [11:0]          in_csr_addr,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 flush,
  output logic [11:0]          csr_addr,
  output logic                 csr_rena,
  output logic                 csr_wena,
  output logic [1:0]           csr_op,
  output logic [XLEN-1:0]      csr_wdata,
  input  logic [XLEN-1:0]      csr_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 csr_illegal
);

  state_t                 state, state_next;
  logic [2:0]             funct3_q;
  logic [11:0]            addr_q;
  logic [REG_IDX_W-1:0]   src_idx_q;
  logic [XLEN-1:0]        rs1_data_q;
  logic [REG_IDX_W-1:0]   rd_q;
  logic [XLEN-1:0]        wb_data_q;
  logic                   illegal_q;

  csr_dec_t               dec;
  logic [XLEN-1:0]        operand;
  logic                   illegal_c;

  assign dec     = csr_decode(funct3_q, rd_q == '0, src_idx_q == '0);
  assign operand = funct3_q[2] ? {{(XLEN-REG_IDX_W){1'b0}}, src_idx_q} : rs1_data_q;

`ifdef CSR_ILLEGAL_CHECK_EN
  assign illegal_c = !dec.valid_op || (dec.wena && (addr_q[11:10] == CSR_RO_RANGE));
`else
  assign illegal_c = 1'b0;
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    csr_addr   = '0;
    csr_rena   = 1'b0;
    csr_wena   = 1'b0;
    csr_op     = '0;
    csr_wdata  = '0;
    wb_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        csr_addr  = addr_q;
        csr_op    = dec.op;
        csr_wdata = operand;
        // a flush kills the access before it has any side effect
        csr_rena  = dec.rena && !flush;
        csr_wena  = dec.wena && !illegal_c && !flush;
        state_next = flush ? ST_IDLE : ST_WB;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      src_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && in_valid && !flush) begin
        funct3_q   <= in_funct3;
        addr_q     <= in_csr_addr;
        src_idx_q  <= in_rs1_idx;
        rs1_data_q <= in_rs1_data;
        rd_q       <= in_rd;
      end
      // the CSR file updates on this same edge, so csr_rdata is the pre-write value
      if (state == ST_ACCESS && !flush) begin
        wb_data_q <= dec.rena ? csr_rdata : '0;
        illegal_q <= illegal_c;
      end
      if (state == ST_WB && wb_ready) illegal_q <= 1'b0;
    end
  end

  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign csr_illegal = illegal_q;

endmodule

// File: tb/tb_csr_issue.sv
// tb/tb_csr_issue.sv - directed table-driven bench for csr_issue with a behavioural CSR file
module tb_csr_issue;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = '0;
  logic [11:0]     in_csr_addr = '0;
  logic [RW-1:0]   in_rs1_idx = '0;
  logic [XLEN-1:0] in_rs1_data = '0;
  logic [RW-1:0]   in_rd = '0;
  logic            flush = 1'b0;
  logic [11:0]     csr_addr;
  logic            csr_rena;
  logic            csr_wena;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            csr_illegal;

  csr_issue #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data),
    .in_rd(in_rd), .flush(flush),
    .csr_addr(csr_addr), .csr_rena(csr_rena), .csr_wena(csr_wena), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  // behavioural CSR file: combinational read, write on posedge
  logic [XLEN-1:0] csr_mem [0:4095];
  logic            pre_en = 1'b0;
  logic [11:0]     pre_addr = '0;
  logic [XLEN-1:0] pre_val = '0;

  assign csr_rdata = csr_rena ? csr_mem[csr_addr] : '0;

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_val;
    else if (csr_wena) begin
      case (csr_op)
        2'b01:   csr_mem[csr_addr] <= csr_wdata;
        2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
        2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
        default: ;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]      funct3;
    logic [11:0]     addr;
    logic [RW-1:0]   rs1_idx;
    logic [XLEN-1:0] rs1_data;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] init;
    logic            exp_rena;
    logic            exp_wena;
    logic [1:0]      exp_op;
    logic [XLEN-1:0] exp_wdata;
    logic [XLEN-1:0] exp_wb;
    logic [XLEN-1:0] exp_final;
    logic            exp_ill;
  } vec_t;

  vec_t vecs [10];

  task automatic preload(input logic [11:0] a, input logic [XLEN-1:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] a, input logic [RW-1:0] idx,
                       input logic [XLEN-1:0] d, input logic [RW-1:0] rd);
    in_valid = 1'b1; in_funct3 = f3; in_csr_addr = a;
    in_rs1_idx = idx; in_rs1_data = d; in_rd = rd;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    preload(v.addr, v.init);
    drive(v.funct3, v.addr, v.rs1_idx, v.rs1_data, v.rd);
    check($sformatf("v%0d in_ready idle", i), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d rena", i), csr_rena, v.exp_rena);
    check($sformatf("v%0d wena", i), csr_wena, v.exp_wena);
    check($sformatf("v%0d op", i), csr_op, v.exp_op);
    check($sformatf("v%0d wdata", i), csr_wdata, v.exp_wdata);
    check($sformatf("v%0d addr", i), csr_addr, v.addr);
    check($sformatf("v%0d access busy", i), {in_ready, wb_valid}, 0);
    @(negedge clk);
    check($sformatf("v%0d wb_valid", i), wb_valid, 1);
    check($sformatf("v%0d wb_rd", i), wb_rd, v.rd);
    check($sformatf("v%0d wb_data", i), wb_data, v.exp_wb);
    check($sformatf("v%0d illegal", i), csr_illegal, v.exp_ill);
    check($sformatf("v%0d csr final", i), csr_mem[v.addr], v.exp_final);
    check($sformatf("v%0d wb bus quiet", i), {csr_rena, csr_wena, csr_addr}, 0);
    @(negedge clk);
    check($sformatf("v%0d back idle", i), {in_ready, wb_valid, csr_illegal}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            f3      addr    idx  rs1_data  rd  init   rena wena op     wdata    wb     final  ill
    vecs[0] = '{3'b001, 12'hB00, 5, 64'h1234, 6, 64'h55, 1, 1, 2'b01, 64'h1234, 64'h55, 64'h1234, 0};
    vecs[1] = '{3'b010, 12'h300, 0, 64'h0,    7, 64'hA5, 1, 0, 2'b10, 64'h0,    64'hA5, 64'hA5,   0};
    vecs[2] = '{3'b001, 12'h340, 3, 64'h77,   0, 64'h99, 0, 1, 2'b01, 64'h77,   64'h0,  64'h77,   0};
    vecs[3] = '{3'b111, 12'h341, 3, 64'hFFFF, 8, 64'hF,  1, 1, 2'b11, 64'h3,    64'hF,  64'hC,    0};
    vecs[4] = '{3'b110, 12'h342, 16, 64'h0,   9, 64'h1,  1, 1, 2'b10, 64'h10,   64'h1,  64'h11,   0};
    vecs[5] = '{3'b010, 12'h343, 2, 64'hF0,   1, 64'h0F, 1, 1, 2'b10, 64'hF0,   64'h0F, 64'hFF,   0};
    vecs[8] = '{3'b010, 12'hC01, 0, 64'h0,   11, 64'h77, 1, 0, 2'b10, 64'h0,    64'h77, 64'h77,   0};
    vecs[9] = '{3'b111, 12'h345, 0, 64'h0,   13, 64'h3C, 1, 0, 2'b11, 64'h0,    64'h3C, 64'h3C,   0};
`ifdef CSR_ILLEGAL_CHECK_EN
    vecs[6] = '{3'b000, 12'h344, 1, 64'h5,    4, 64'h33, 0, 0, 2'b00, 64'h5,    64'h0,  64'h33,   1};
    vecs[7] = '{3'b001, 12'hC00, 5, 64'hDEAD, 10, 64'h42, 1, 0, 2'b01, 64'hDEAD, 64'h42, 64'h42,  1};
`else
    vecs[6] = '{3'b000, 12'h344, 1, 64'h5,    4, 64'h33, 0, 0, 2'b00, 64'h5,    64'h0,  64'h33,   0};
    vecs[7] = '{3'b001, 12'hC00, 5, 64'hDEAD, 10, 64'h42, 1, 1, 2'b01, 64'hDEAD, 64'h42, 64'hDEAD, 0};
`endif

    #3;
    check("reset in_ready", in_ready, 1);
    check("reset outputs", {csr_rena, csr_wena, wb_valid, csr_illegal}, 0);
    check("reset wb_rd", wb_rd, 0);
    check("reset wb_data", wb_data, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    drive(3'b001, 12'h351, 1, 64'h9, 2);
    flush = 1'b1;
    @(negedge clk);
    check("flush idle in_ready", in_ready, 1);
    check("flush idle no access", csr_rena | csr_wena, 0);
    in_valid = 1'b0; flush = 1'b0;

    // flush in ACCESS: no side effect, no writeback
    preload(12'h350, 64'h11);
    drive(3'b001, 12'h350, 1, 64'h22, 3);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush access rena", csr_rena, 0);
    check("flush access wena", csr_wena, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush access wb_valid", wb_valid, 0);
    check("flush access in_ready", in_ready, 1);
    check("flush access csr kept", csr_mem[12'h350], 64'h11);

    // writeback back-pressure, flush ignored in WB, new instruction stalled
    preload(12'h360, 64'hAB);
    wb_ready = 1'b0;
    drive(3'b001, 12'h360, 4, 64'h1, 12);
    @(negedge clk);
    drive(3'b001, 12'h361, 4, 64'h2, 14);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      flush = (k == 1);
      check($sformatf("stall%0d wb_valid", k), wb_valid, 1);
      check($sformatf("stall%0d wb_data", k), wb_data, 64'hAB);
      check($sformatf("stall%0d wb_rd", k), wb_rd, 12);
      check($sformatf("stall%0d in_ready", k), in_ready, 0);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    check("stall release wb_valid", wb_valid, 0);
    check("stall release in_ready", in_ready, 1);
    check("stall second not taken", csr_mem[12'h361] === 64'h2, 0);

    // asynchronous reset while in WB
    preload(12'h370, 64'h66);
    wb_ready = 1'b0;
    drive(3'b010, 12'h370, 0, 64'h0, 15);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset wb_valid", wb_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("async reset wb_valid", wb_valid, 0);
    check("async reset in_ready", in_ready, 1);
    check("async reset wb_data", wb_data, 0);
    check("async reset wb_rd", wb_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    @(negedge clk);
    check("post-reset idle", {in_ready, wb_valid}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
